fib_job_sched: RTL
==================

// Module: fib_job_sched
// PURPOSE
//   Shares one iterative Fibonacci engine between two requesters. Each requester
//   submits an index N over a valid/ready handshake. The block arbitrates round-robin,
//   steps the add/shift recurrence N times, and returns F(N) with a requester ID and
//   an overflow flag over a valid/ready response channel. One job is in flight at a time.
// PARAMETERS
//   WIDTH  32  result and datapath width in bits
//   IDX_W  6   width of requested index N (max N = 2**IDX_W-1)
// PORTS
//   clk         in   1      clock, all state updates on rising edge
//   rst         in   1      asynchronous reset, active-low (0 = reset)
//   req0_valid  in   1      requester 0 has a job
//   req0_idx    in   IDX_W  requester 0 index N
//   req0_ready  out  1      requester 0 job accepted this cycle
//   req1_valid  in   1      requester 1 has a job
//   req1_idx    in   IDX_W  requester 1 index N
//   req1_ready  out  1      requester 1 job accepted this cycle
//   rsp_valid   out  1      result available
//   rsp_ready   in   1      consumer takes result
//   rsp_id      out  1      requester that owns the result (0/1)
//   rsp_value   out  WIDTH  F(N) mod 2**WIDTH
//   rsp_ovf     out  1      F(N) did not fit in WIDTH bits
//   busy        out  1      state != IDLE
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, rsp_valid=0, rsp_id=0, rsp_value=0, rsp_ovf=0,
//     cnt=0, last_grant=1 (req0 wins first tie). reqX_ready forced 0 while rst=0.
//   - FSM states: IDLE, RUN, DONE.
//   - IDLE: reqX_ready is combinational and is high only for the granted requester.
//     Grant rules: only one valid -> that requester wins. Both valid -> the requester
//     != last_grant wins. On the accept edge: latch id, cnt<=idx, cur<=0, nxt<=1,
//     cur_ovf<=0, nxt_ovf<=0; go to RUN. last_grant<=id.
//   - RUN, cnt!=0: cur<=nxt; nxt<=cur+nxt (truncated to WIDTH bits);
//     nxt_ovf<=nxt_ovf|carry_out; cur_ovf<=nxt_ovf; cnt<=cnt-1.
//   - RUN, cnt==0: go to DONE. rsp_value=cur, rsp_ovf=cur_ovf, rsp_id=latched id.
//   - Latency: rsp_valid rises N+1 cycles after the accept edge (N=0 -> 1 cycle).
//   - DONE: rsp_valid=1. rsp_id, rsp_value and rsp_ovf are held stable until
//     rsp_valid&&rsp_ready. On that edge go to IDLE. No request is accepted in DONE.
//     This gives a one-cycle bubble between jobs.
//   - Requests are never accepted in RUN or DONE, and reqX_ready=0 in those states.
//     Requesters must hold valid/idx stable until ready.
//   - After the response handshake, rsp_value/rsp_id/rsp_ovf keep their last values.
//     rsp_valid=0.
//   - Overflow: rsp_ovf=1 iff the true F(N) >= 2**WIDTH. The flag is sticky through
//     the recurrence. The value wraps modulo 2**WIDTH.
//   - Reset asserted mid-RUN or mid-DONE aborts the job with no response. After
//     release, behaviour is identical to power-on.
// TESTING
//   1 req0 idx=10 alone, rsp_ready=1 -> rsp_value=55, rsp_ovf=0, rsp_id=0, 11 cyc after accept
//   2 req0 idx=5 and req1 idx=7 valid same cycle after reset -> req0 served first (5),
//     then req1 (13, id=1)
//   3 both valid continuously, idx=3 -> grants alternate 0,1,0,1; rsp_id alternates, value=2
//   4 idx=47 -> 2971215073, ovf=0; idx=48 -> 512559680, ovf=1; idx=0 -> 0 after 1 cycle
//   5 rsp_ready=0 for 5 cycles in DONE -> rsp fields stable, req ready stays 0, busy=1
//   6 rst=0 during RUN of idx=20 -> all outputs reset immediately; next idx=20 -> 6765

Source files
------------

// File: rtl/fib_job_sched.sv
// fib_job_sched: one iterative Fibonacci engine shared round-robin by two requesters
// Ports:
//   clk, rst (async, active-low)
//   req0_valid/req0_idx/req0_ready, req1_valid/req1_idx/req1_ready : job submission
//   rsp_valid/rsp_ready/rsp_id/rsp_value/rsp_ovf                    : result channel
//   busy                                                             : engine not idle
module fib_job_sched #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [IDX_W-1:0] req0_idx,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [IDX_W-1:0] req1_idx,
   output logic             req1_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_value,
   output logic             rsp_ovf,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nxt;
   logic             last_grant, id, cur_ovf, nxt_ovf;
   logic             g0, g1, accept;
   logic [IDX_W-1:0] cnt, grant_idx;
   logic [WIDTH-1:0] cur, nxt;
   logic [WIDTH:0]   sum;
   // on a tie the requester that was not granted last time wins
   always_comb begin
      g0 = req0_valid && (!req1_valid || last_grant);
      g1 = req1_valid && (!req0_valid || !last_grant);
      req0_ready = rst && state == IDLE && g0;
      req1_ready = rst && state == IDLE && g1;
      accept = req0_ready || req1_ready;
      grant_idx = g1 ? req1_idx : req0_idx;
      sum = {1'b0, cur} + {1'b0, nxt};
      busy = state != IDLE;
      rsp_valid = state == DONE;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept ? RUN : IDLE;
         RUN:     state_nxt = cnt == '0 ? DONE : RUN;
         DONE:    state_nxt = rsp_ready ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else state <= state_nxt;
   end
   // nxt_ovf marks that the true value behind nxt no longer fits; cur inherits it one step later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= 1'b1;
         id <= 1'b0;
         cnt <= '0;
         cur <= '0;
         nxt <= '0;
         cur_ovf <= 1'b0;
         nxt_ovf <= 1'b0;
         rsp_id <= 1'b0;
         rsp_value <= '0;
         rsp_ovf <= 1'b0;
      end else begin
         if (accept) begin
            id <= g1;
            last_grant <= g1;
            cnt <= grant_idx;
            cur <= '0;
            nxt <= WIDTH'(1);
            cur_ovf <= 1'b0;
            nxt_ovf <= 1'b0;
         end
         if (state == RUN && cnt != '0) begin
            cur <= nxt;
            nxt <= sum[WIDTH-1:0];
            nxt_ovf <= nxt_ovf | sum[WIDTH];
            cur_ovf <= nxt_ovf;
            cnt <= cnt - IDX_W'(1);
         end
         if (state == RUN && cnt == '0) begin
            rsp_id <= id;
            rsp_value <= cur;
            rsp_ovf <= cur_ovf;
         end
      end
   end
endmodule
